// File: rtl/fft_pkg.sv
// Shared FFT fixed-point definitions: default widths, twiddle rounding constant,
// saturation limits and the per-stage twiddle exponent.
package fft_pkg;

    localparam int BIT_WIDTH = 16;
    localparam int TW_WIDTH  = 16;
    localparam int LOG2N     = 10;

    // Half an LSB of the Q1.(tw_width-1) product, added before the shift.
    function automatic int roundConst(input int twWidth);
        return 1 << (twWidth - 2);
    endfunction

    function automatic int satMax(input int width);
        return (1 << (width - 1)) - 1;
    endfunction

    function automatic int satMin(input int width);
        return -(1 << (width - 1));
    endfunction

    // e = (k mod 2^stage) * (N >> (stage+1)); the modulo reduces to a mask.
    function automatic int twExp(input int k, input int stg, input int lg);
        return (k & ((1 << stg) - 1)) * ((1 << lg) >> (stg + 1));
    endfunction

endpackage

// File: rtl/twiddle_rom.sv
// Twiddle ROM with a one-cycle synchronous read of (cos, sin) at exponent e.
// Build option TW_ROM_QUARTER_EN: quarter-wave cosine table with index/sign folding.
module twiddle_rom
    import fft_pkg::*;
#(
    parameter int tw_width = TW_WIDTH,
    parameter int log2N    = LOG2N
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rd_en_i,
    input  logic [log2N-2:0]           addr_i,
    output logic signed [tw_width-1:0] c_o,
    output logic signed [tw_width-1:0] d_o
);

    localparam int  N  = 1 << log2N;
    localparam int  AW = log2N - 1;
    localparam real PI = 3.14159265358979323846;

    // round(v * 2^(tw_width-1)) half up; +1.0 clamps to the largest code.
    function automatic logic signed [tw_width-1:0] quant(input real v);
        real x;
        int  r;
        x = v * real'(1 << (tw_width - 1)) + 0.5;
        r = $rtoi(x);
        if (real'(r) > x) r = r - 1;
        if (r > satMax(tw_width)) r = satMax(tw_width);
        return tw_width'(r);
    endfunction

`ifdef TW_ROM_QUARTER_EN

    localparam int            QTR   = N / 4;
    localparam logic [AW-1:0] QTR_A = AW'(QTR);

    logic signed [tw_width-1:0] qTab [QTR+1];
    logic [AW-1:0]              cIdx;
    logic [AW-1:0]              dIdx;
    logic                       cNeg;

    for (genvar i = 0; i <= QTR; i++) begin : g_qtab
        localparam logic signed [tw_width-1:0] QV = quant($cos(2.0 * PI * i / N));
        assign qTab[i] = QV;
    end

    // Second quadrant: cos(theta) = -cos(pi - theta), sin(theta) = cos(theta - pi/2).
    always_comb begin
        cNeg = 1'b0;
        cIdx = addr_i;
        dIdx = QTR_A - addr_i;
        if (addr_i > QTR_A) begin
            cNeg = 1'b1;
            cIdx = '0 - addr_i;
            dIdx = addr_i - QTR_A;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            c_o <= '0;
            d_o <= '0;
        end else if (rd_en_i) begin
            c_o <= cNeg ? -qTab[cIdx] : qTab[cIdx];
            d_o <= qTab[dIdx];
        end
    end

`else

    logic signed [tw_width-1:0] cTab [N/2];
    logic signed [tw_width-1:0] sTab [N/2];

    for (genvar i = 0; i < N / 2; i++) begin : g_tab
        localparam logic signed [tw_width-1:0] CV = quant($cos(2.0 * PI * i / N));
        localparam logic signed [tw_width-1:0] SV = quant($sin(2.0 * PI * i / N));
        assign cTab[i] = CV;
        assign sTab[i] = SV;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            c_o <= '0;
            d_o <= '0;
        end else if (rd_en_i) begin
            c_o <= cTab[addr_i];
            d_o <= sTab[addr_i];
        end
    end

`endif

endmodule

// File: rtl/twiddle_rotator.sv
// Pipelined twiddle rotator: rotates the lower sample by W_N^e for one DIT stage and
// delays the upper sample to match. Build option TW_ROM_QUARTER_EN selects the ROM variant.
module twiddle_rotator
    import fft_pkg::*;
#(
    parameter int bit_width = BIT_WIDTH,
    parameter int tw_width  = TW_WIDTH,
    parameter int log2N     = LOG2N,
    parameter int stage     = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        frame_start,
    input  logic signed [bit_width-1:0] xin1,
    input  logic signed [bit_width-1:0] yin1,
    input  logic signed [bit_width-1:0] xin2,
    input  logic signed [bit_width-1:0] yin2,
    output logic signed [bit_width-1:0] xout1,
    output logic signed [bit_width-1:0] yout1,
    output logic signed [bit_width-1:0] xout2,
    output logic signed [bit_width-1:0] yout2,
    output logic                        valid_out
);

    localparam int KW   = log2N - 1;
    localparam int PW   = bit_width + tw_width;
    localparam int SW   = PW + 1;
    localparam int FRAC = tw_width - 1;

    localparam logic signed [SW-1:0] ROUND  = SW'(roundConst(tw_width));
    localparam logic signed [SW-1:0] SAT_HI = SW'(satMax(bit_width));
    localparam logic signed [SW-1:0] SAT_LO = SW'(satMin(bit_width));

    function automatic logic signed [bit_width-1:0] satNarrow(input logic signed [SW-1:0] v);
        if (v > SAT_HI) return {1'b0, {(bit_width-1){1'b1}}};
        else if (v < SAT_LO) return {1'b1, {(bit_width-1){1'b0}}};
        else return v[bit_width-1:0];
    endfunction

    logic [KW-1:0] k_q;
    logic [KW-1:0] k_d;
    logic [KW-1:0] kCur;
    logic [KW-1:0] eAddr;

    // frame_start restarts the count at 0 for this pair; k wraps naturally at N/2.
    always_comb begin
        kCur  = frame_start ? '0 : k_q;
        eAddr = KW'(twExp(int'(kCur), stage, log2N));
        k_d   = en ? kCur + KW'(1) : k_q;
    end

    always_ff @(posedge clk) begin
        if (rst) k_q <= '0;
        else     k_q <= k_d;
    end

    logic signed [tw_width-1:0] cS1;
    logic signed [tw_width-1:0] dS1;

    twiddle_rom #(
        .tw_width (tw_width),
        .log2N    (log2N)
    ) u_rom (
        .clk     (clk),
        .rst     (rst),
        .rd_en_i (en),
        .addr_i  (eAddr),
        .c_o     (cS1),
        .d_o     (dS1)
    );

    logic                        v1_q;
    logic signed [bit_width-1:0] a1_q;
    logic signed [bit_width-1:0] b1_q;
    logic signed [bit_width-1:0] u1x_q;
    logic signed [bit_width-1:0] u1y_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q  <= 1'b0;
            a1_q  <= '0;
            b1_q  <= '0;
            u1x_q <= '0;
            u1y_q <= '0;
        end else begin
            v1_q <= en;
            if (en) begin
                a1_q  <= xin2;
                b1_q  <= yin2;
                u1x_q <= xin1;
                u1y_q <= yin1;
            end
        end
    end

    logic                        v2_q;
    logic signed [PW-1:0]        ac_q;
    logic signed [PW-1:0]        bd_q;
    logic signed [PW-1:0]        bc_q;
    logic signed [PW-1:0]        ad_q;
    logic signed [bit_width-1:0] u2x_q;
    logic signed [bit_width-1:0] u2y_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            v2_q  <= 1'b0;
            ac_q  <= '0;
            bd_q  <= '0;
            bc_q  <= '0;
            ad_q  <= '0;
            u2x_q <= '0;
            u2y_q <= '0;
        end else begin
            v2_q <= v1_q;
            if (v1_q) begin
                ac_q  <= PW'(a1_q) * PW'(cS1);
                bd_q  <= PW'(b1_q) * PW'(dS1);
                bc_q  <= PW'(b1_q) * PW'(cS1);
                ad_q  <= PW'(a1_q) * PW'(dS1);
                u2x_q <= u1x_q;
                u2y_q <= u1y_q;
            end
        end
    end

    logic signed [SW-1:0]        sumX;
    logic signed [SW-1:0]        sumY;
    logic signed [SW-1:0]        shX;
    logic signed [SW-1:0]        shY;
    logic signed [bit_width-1:0] xSat;
    logic signed [bit_width-1:0] ySat;

    // Multiplying by conj(W) = c - jd rotates clockwise by the twiddle angle.
    always_comb begin
        sumX = SW'(ac_q) + SW'(bd_q) + ROUND;
        sumY = SW'(bc_q) - SW'(ad_q) + ROUND;
        shX  = sumX >>> FRAC;
        shY  = sumY >>> FRAC;
        xSat = satNarrow(shX);
        ySat = satNarrow(shY);
    end

    logic                        v3_q;
    logic signed [bit_width-1:0] xo1_q;
    logic signed [bit_width-1:0] yo1_q;
    logic signed [bit_width-1:0] xo2_q;
    logic signed [bit_width-1:0] yo2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            v3_q  <= 1'b0;
            xo1_q <= '0;
            yo1_q <= '0;
            xo2_q <= '0;
            yo2_q <= '0;
        end else begin
            v3_q <= v2_q;
            if (v2_q) begin
                xo1_q <= u2x_q;
                yo1_q <= u2y_q;
                xo2_q <= xSat;
                yo2_q <= ySat;
            end
        end
    end

    assign xout1     = xo1_q;
    assign yout1     = yo1_q;
    assign xout2     = xo2_q;
    assign yout2     = yo2_q;
    assign valid_out = v3_q;

endmodule

// File: tb/tb_twiddle_rotator.sv
// Randomised bench for twiddle_rotator at stages 0 and 9 (N=1024), checked every
// cycle against a queue-based behavioural model plus hand-computed literal cases.
module tb_twiddle_rotator;

    localparam real PI = 3.14159265358979323846;

    logic               clk;
    logic               rst;
    logic               en;
    logic               frameStart;
    logic signed [15:0] xin1, yin1, xin2, yin2;
    logic signed [15:0] xo1A, yo1A, xo2A, yo2A;
    logic signed [15:0] xo1B, yo1B, xo2B, yo2B;
    logic               validA, validB;
    int                 curTag;

    int total = 0;
    int bad   = 0;
    int hit1 = 0, hit2 = 0, hit3 = 0, hit4 = 0;

    twiddle_rotator #(.bit_width(16), .tw_width(16), .log2N(10), .stage(0)) dutS0 (
        .clk(clk), .rst(rst), .en(en), .frame_start(frameStart),
        .xin1(xin1), .yin1(yin1), .xin2(xin2), .yin2(yin2),
        .xout1(xo1A), .yout1(yo1A), .xout2(xo2A), .yout2(yo2A),
        .valid_out(validA)
    );

    twiddle_rotator #(.bit_width(16), .tw_width(16), .log2N(10), .stage(9)) dutS9 (
        .clk(clk), .rst(rst), .en(en), .frame_start(frameStart),
        .xin1(xin1), .yin1(yin1), .xin2(xin2), .yin2(yin2),
        .xout1(xo1B), .yout1(yo1B), .xout2(xo2B), .yout2(yo2B),
        .valid_out(validB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

    task automatic checkOutput(input string name, input int actual, input int want);
        total++;
        if (actual !== want) begin
            bad++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, want);
        end
    endtask

    // Behavioural reference: real-valued twiddle, round half up, exact integer product.
    function automatic int quantTw(input real v);
        real x;
        int  r;
        x = v * 32768.0 + 0.5;
        r = $rtoi(x);
        if (real'(r) > x) r = r - 1;
        if (r > 32767) r = 32767;
        return r;
    endfunction

    function automatic int clamp16(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    function automatic int twExpModel(input int k, input int s);
        return (k % (1 << s)) * (1024 >> (s + 1));
    endfunction

    function automatic void rotate(input int a, input int b, input int eIdx,
                                   output int xr, output int yr);
        real    ang;
        longint c, d, sx, sy;
        ang = 2.0 * PI * real'(eIdx) / 1024.0;
        c   = longint'(quantTw($cos(ang)));
        d   = longint'(quantTw($sin(ang)));
        sx  = longint'(a) * c + longint'(b) * d + 16384;
        sy  = longint'(b) * c - longint'(a) * d + 16384;
        xr  = clamp16(sx >>> 15);
        yr  = clamp16(sy >>> 15);
    endfunction

    typedef struct {
        bit v;
        int tag;
        int x1, y1, x2a, y2a, x2b, y2b;
    } entry_t;

    entry_t pipeQ[$];
    int     kModel    = 0;
    bit     modelLive = 0;
    bit     expValid  = 0;
    int     expTag    = 0;
    int     expX1 = 0, expY1 = 0, expX2a = 0, expY2a = 0, expX2b = 0, expY2b = 0;

    // Each accepted cycle leaves the pipeline two edges later; reset flushes it.
    always @(posedge clk) begin : model
        entry_t ent, old, blank;
        int     kUse;
        blank = '{default: 0};
        if (rst) begin
            pipeQ.delete();
            pipeQ.push_back(blank);
            pipeQ.push_back(blank);
            kModel   <= 0;
            expValid <= 0;
            expTag   <= 0;
            expX1 <= 0; expY1 <= 0; expX2a <= 0; expY2a <= 0; expX2b <= 0; expY2b <= 0;
        end else begin
            ent = blank;
            if (en) begin
                kUse    = frameStart ? 0 : kModel;
                kModel <= (kUse + 1) % 512;
                ent.v   = 1;
                ent.tag = curTag;
                ent.x1  = int'(xin1);
                ent.y1  = int'(yin1);
                rotate(int'(xin2), int'(yin2), twExpModel(kUse, 0), ent.x2a, ent.y2a);
                rotate(int'(xin2), int'(yin2), twExpModel(kUse, 9), ent.x2b, ent.y2b);
            end
            pipeQ.push_back(ent);
            old = pipeQ.pop_front();
            expValid <= old.v;
            expTag   <= old.v ? old.tag : 0;
            if (old.v) begin
                expX1 <= old.x1; expY1 <= old.y1;
                expX2a <= old.x2a; expY2a <= old.y2a;
                expX2b <= old.x2b; expY2b <= old.y2b;
            end
        end
        modelLive <= 1;
    end

    always @(negedge clk) begin
        if (modelLive) begin
            checkOutput("valid_s0", int'(validA), int'(expValid));
            checkOutput("valid_s9", int'(validB), int'(expValid));
            checkOutput("xout1_s0", int'(xo1A), expX1);
            checkOutput("yout1_s0", int'(yo1A), expY1);
            checkOutput("xout1_s9", int'(xo1B), expX1);
            checkOutput("yout1_s9", int'(yo1B), expY1);
            checkOutput("xout2_s0", int'(xo2A), expX2a);
            checkOutput("yout2_s0", int'(yo2A), expY2a);
            checkOutput("xout2_s9", int'(xo2B), expX2b);
            checkOutput("yout2_s9", int'(yo2B), expY2b);
            if (expValid && expTag == 1) begin
                hit1++;
                checkOutput("lit_k0_s0_xout2", int'(xo2A), 1000);
                checkOutput("lit_k0_s0_yout2", int'(yo2A), 0);
                checkOutput("lit_k0_s0_xout1", int'(xo1A), 5);
                checkOutput("lit_k0_s9_xout2", int'(xo2B), 1000);
                checkOutput("lit_k0_s9_yout2", int'(yo2B), 0);
            end
            if (expValid && expTag == 2) begin
                hit2++;
                checkOutput("lit_k128_s9_xout2", int'(xo2B), -32768);
                checkOutput("lit_k128_s9_yout2", int'(yo2B), 0);
            end
            if (expValid && expTag == 3) begin
                hit3++;
                checkOutput("lit_k256_s9_xout2", int'(xo2B), 0);
                checkOutput("lit_k256_s9_yout2", int'(yo2B), -1000);
            end
            if (expValid && expTag == 4) begin
                hit4++;
                checkOutput("lit_frame2_s9_xout2", int'(xo2B), 1000);
                checkOutput("lit_frame2_s9_yout2", int'(yo2B), 0);
            end
        end
    end

    task automatic applyStimulus(input bit r, input bit e, input bit fs,
                                 input int x1, input int y1, input int x2, input int y2,
                                 input int tag);
        @(negedge clk);
        rst        = r;
        en         = e;
        frameStart = fs;
        xin1       = 16'(x1);
        yin1       = 16'(y1);
        xin2       = 16'(x2);
        yin2       = 16'(y2);
        curTag     = tag;
    endtask

    function automatic int rnd16();
        int sel;
        sel = int'($urandom_range(0, 15));
        if (sel == 0) return -32768;
        if (sel == 1) return 32767;
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    initial begin : stim
        int  px, py, kn;
        bit  re, ee, fe;

        rst = 1'b1; en = 1'b0; frameStart = 1'b0; curTag = 0;
        xin1 = '0; yin1 = '0; xin2 = '0; yin2 = '0;

        checkOutput("model_q_cos45", quantTw($cos(PI / 4.0)), 23170);
        rotate(1000, 0, 256, px, py);
        checkOutput("model_wmj_x", px, 0);
        checkOutput("model_wmj_y", py, -1000);
        rotate(-32768, -32768, 128, px, py);
        checkOutput("model_sat_x", px, -32768);
        checkOutput("model_sat_y", py, 0);

        repeat (3) applyStimulus(1, 1, 0, 7, 7, 7, 7, 0);
        @(posedge clk); #1;
        checkOutput("reset_valid_s0", int'(validA), 0);
        checkOutput("reset_valid_s9", int'(validB), 0);
        checkOutput("reset_xout2_s0", int'(xo2A), 0);
        checkOutput("reset_xout1_s9", int'(xo1B), 0);

        applyStimulus(0, 1, 1, 5, 0, 1000, 0, 1);
        applyStimulus(0, 0, 0, rnd16(), rnd16(), rnd16(), rnd16(), 0);
        applyStimulus(0, 1, 0, rnd16(), rnd16(), rnd16(), rnd16(), 0);
        applyStimulus(0, 1, 0, rnd16(), rnd16(), rnd16(), rnd16(), 0);

        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            kn = kModel;
            if (kn == 128) begin
                applyStimulus(0, 1, 0, rnd16(), rnd16(), -32768, -32768, 2);
            end else if (kn == 256) begin
                applyStimulus(0, 1, 0, rnd16(), rnd16(), 1000, 0, 3);
                break;
            end else begin
                applyStimulus(0, 1, 0, rnd16(), rnd16(), rnd16(), rnd16(), 0);
            end
        end

        for (int p = 0; p < 600; p++) begin
            if (p == 512) applyStimulus(0, 1, 1, 5, 0, 1000, 0, 4);
            else          applyStimulus(0, 1, p == 0, rnd16(), rnd16(), rnd16(), rnd16(), 0);
        end

        applyStimulus(0, 1, 0, rnd16(), rnd16(), rnd16(), rnd16(), 0);
        applyStimulus(0, 1, 0, rnd16(), rnd16(), rnd16(), rnd16(), 0);
        applyStimulus(1, 1, 0, rnd16(), rnd16(), rnd16(), rnd16(), 0);
        @(posedge clk); #1;
        checkOutput("midrst_valid_s0", int'(validA), 0);
        checkOutput("midrst_valid_s9", int'(validB), 0);
        checkOutput("midrst_xout2_s9", int'(xo2B), 0);
        checkOutput("midrst_xout1_s0", int'(xo1A), 0);
        applyStimulus(0, 0, 0, rnd16(), rnd16(), rnd16(), rnd16(), 0);
        applyStimulus(0, 1, 0, 5, 0, 1000, 0, 1);

        for (int i = 0; i < 2000; i++) begin
            re = ($urandom_range(0, 99) == 0);
            ee = ($urandom_range(0, 9) < 7);
            fe = ($urandom_range(0, 29) == 0);
            applyStimulus(re, ee, fe, rnd16(), rnd16(), rnd16(), rnd16(), 0);
        end

        repeat (6) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        checkOutput("hits_k0", hit1, 2);
        checkOutput("hits_k128", hit2, 1);
        checkOutput("hits_k256", hit3, 1);
        checkOutput("hits_frame2", hit4, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/twiddle_rotator.md
# twiddle_rotator

Pipelined twiddle-factor complex multiplier. It sits directly upstream of the radix-2 butterfly adder in each FFT stage. It takes a pair of complex samples and multiplies the second sample by the stage twiddle W_N^e. It delays the first sample to stay aligned with the product, then presents both to the butterfly together with a valid strobe that drives the butterfly's enable.

## Interface
- bit_width, 16, signed sample width (real and imaginary parts)
- tw_width, 16, signed twiddle width, Q1.(tw_width-1)
- log2N, 10, log2 of FFT length N
- stage, 0, DIT stage index, 0..log2N-1; butterfly span 2^stage

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  input pair valid, one pair per cycle, no backpressure
- frame_start  in  1  qualified by en; marks pair 0 of a frame
- xin1, yin1  in  bit_width  upper sample (re, im), signed
- xin2, yin2  in  bit_width  lower sample (re, im), signed, to be rotated
- xout1, yout1  out  bit_width  upper sample delayed by 3 cycles
- xout2, yout2  out  bit_width  rotated lower sample
- valid_out  out  1  output pair valid; connects to the butterfly en

## Operation
- Pair counter k runs over 0..N/2-1 and advances on each en. It wraps from N/2-1 to 0.
- en with frame_start forces k=0 for that pair. The next pair uses k=1.
- Twiddle exponent: e = (k mod 2^stage) * (N >> (stage+1)), with range 0..N/2-1.
- Twiddle values: c = cos(2πe/N), d = sin(2πe/N), quantised to round(v·2^(tw_width-1)). Both values are clamped to 2^(tw_width-1)-1, so W=1 becomes 0x7FFF.
- Product: (a+jb)(c−jd). xout2 = sat((a·c + b·d + R) >>> (tw_width-1)). yout2 = sat((b·c − a·d + R) >>> (tw_width-1)).
  - R = 2^(tw_width-2), i.e. round half up.
  - The shift is arithmetic.
- Width rules:
  - Each product is bit_width+tw_width bits.
  - Each sum is bit_width+tw_width+1 bits.
  - sat clamps to [−2^(bit_width-1), 2^(bit_width-1)−1].
- No per-cycle state beyond k and the pipeline registers. The output registers hold their last value when valid_out=0.

## Timing
- Latency is 3 cycles from en to valid_out.
  - S1: register the inputs, the ROM read of (c, d) and the valid bit.
  - S2: register the four products.
  - S3: register the rounded, saturated sums, plus xin1/yin1 delayed.
- Throughput is one pair per cycle. Bubbles in en propagate unchanged to valid_out.
- Reset values:
  - All outputs 0.
  - valid_out 0.
  - k 0.
  - All pipeline valid bits 0.
- rst mid-stream:
  - In-flight pairs are discarded.
  - valid_out is 0 starting the cycle after rst is sampled.
  - The first en after rst deasserts uses k=0.
- rst and en in the same cycle: rst wins and the pair is dropped.
- frame_start without en is ignored.
- Back-to-back frames need no idle cycle.

## Configuration
- TW_ROM_QUARTER_EN defined:
  - The twiddle ROM stores N/4+1 quarter-wave cosine entries.
  - Sine and cosine are derived by index mirroring and sign fold, with the fold registered inside S1.
- TW_ROM_QUARTER_EN undefined:
  - The ROM stores N/2 entries of (c, d) directly.
- Outputs and latency are bit-identical in both builds.

## Structure
- Shared package fft_pkg holds:
  - the Q-format constants (tw_width, rounding constant R);
  - the sat limits;
  - a function computing e from k, stage and log2N.
- Sub-module twiddle_rom:
  - Synchronous read, one-cycle latency, address e, outputs c and d.
  - Contains the TW_ROM_QUARTER_EN variants.
- The rotator holds the counter, the multiply/round/saturate pipeline and the delay line.

## Test plan
- stage=0, xin2=1000, yin2=0, xin1=5 -> 3 cycles later: xout2=1000, yout2=0, xout1=5, valid_out=1.
- stage=9, N=1024, pair k=256 (e=256, W=−j), xin2=1000, yin2=0 -> xout2=0, yout2=−1000.
- stage=9, k=128 (c=d=23170), xin2=yin2=−32768 -> xout2=−32768 (saturated), yout2=0.
- en pattern 1,0,1,1 -> valid_out pattern 1,0,1,1 delayed 3 cycles. The counter k advances only on en.
- 600 pairs with frame_start on pair 0 and pair 512 -> k sequence 0..511, 0..87; the twiddle on the second pair 0 equals W^0.
- rst asserted one cycle while 2 pairs are in flight -> no valid_out for those pairs, all outputs 0, next pair uses k=0.
